// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered channel mux with manual select or dwell-based round-robin scan,
// valid/ready output handshake, wrap and out-of-range error pulses.
module mux_scan_reg #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int DWELL = 2,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] w,
  input  logic [SW-1:0] s,
  input  logic          mode,
  input  logic          en,
  input  logic          f_ready,
  output logic [W-1:0]  f,
  output logic [SW-1:0] ch,
  output logic          f_valid,
  output logic          wrap,
  output logic          err
);
  typedef enum logic {MANUAL, SCAN} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, ptr_cur, ptr_inc, sel, ch_d;
  logic [7:0] dcnt_q, dcnt_d, dcnt_cur, dcnt_inc;
  logic [W-1:0] f_d, data;
  logic fv_d, wrap_d, err_d, cap, scan_cap, enter_scan, oor, last, at_end;
  always_ff @(posedge clk) state_q <= rst ? MANUAL : state_d;
  always_comb state_d = mode ? SCAN : MANUAL;
  // entering scan restarts the sweep, and a capture in that same cycle already sees channel 0
  assign enter_scan = (state_q == MANUAL) && mode;
  assign ptr_cur = enter_scan ? '0 : ptr_q;
  assign dcnt_cur = enter_scan ? '0 : dcnt_q;
  assign cap = en && (!f_valid || f_ready);
  assign scan_cap = cap && mode;
  assign sel = mode ? ptr_cur : s;
  assign oor = !mode && (32'(s) >= 32'(N));
  assign dcnt_inc = dcnt_cur + 8'd1;
  assign last = dcnt_inc == 8'(DWELL);
  assign at_end = ptr_cur == SW'(N - 1);
  assign ptr_inc = at_end ? '0 : ptr_cur + SW'(1);
  // unmatched (out-of-range) selects fall through to zero
  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) data = (sel == SW'(k)) ? w[k*W +: W] : data;
  end
  always_comb begin
    f_d = cap ? data : f;
    ch_d = cap ? sel : ch;
    fv_d = cap || (f_valid && !f_ready);
    err_d = cap && oor;
    wrap_d = scan_cap && last && at_end;
    dcnt_d = scan_cap ? (last ? '0 : dcnt_inc) : dcnt_cur;
    ptr_d = (scan_cap && last) ? ptr_inc : ptr_cur;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      f <= '0;
      ch <= '0;
      f_valid <= 1'b0;
      wrap <= 1'b0;
      err <= 1'b0;
      ptr_q <= '0;
      dcnt_q <= '0;
    end else begin
      f <= f_d;
      ch <= ch_d;
      f_valid <= fv_d;
      wrap <= wrap_d;
      err <= err_d;
      ptr_q <= ptr_d;
      dcnt_q <= dcnt_d;
    end
  end
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed scenarios plus random traffic on an N=4 and an N=3 instance,
// scoreboarded against a behavioural model.
module tb_mux_scan_reg;
  typedef struct packed {logic [7:0] f; logic [1:0] ch; logic wrap; logic err;} exp_t;
  localparam int DW = 2;
  logic clk = 0, rst = 1, mode = 0, en = 0, f_ready = 0;
  logic [31:0] w = 0;
  logic [1:0] s = 0;
  logic [7:0] fo[2];
  logic [1:0] cho[2];
  logic fvo[2], wro[2], ero[2];
  exp_t fifo[2][16];
  int wp[2], rp[2], mptr[2], mdcnt[2];
  bit mprev[2], mv[2], pv[2];
  logic [7:0] lf[2];
  logic [1:0] lc[2];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mux_scan_reg #(.N(4), .W(8), .DWELL(DW)) dut4 (.clk(clk), .rst(rst), .w(w), .s(s), .mode(mode),
    .en(en), .f_ready(f_ready), .f(fo[0]), .ch(cho[0]), .f_valid(fvo[0]), .wrap(wro[0]), .err(ero[0]));
  mux_scan_reg #(.N(3), .W(8), .DWELL(DW)) dut3 (.clk(clk), .rst(rst), .w(w[23:0]), .s(s), .mode(mode),
    .en(en), .f_ready(f_ready), .f(fo[1]), .ch(cho[1]), .f_valid(fvo[1]), .wrap(wro[1]), .err(ero[1]));
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s dut_n%0d: got %h expected %h at %0t", nm, (i == 0) ? 4 : 3, act, exp_v, $time);
    end
  endtask
  // Behavioural model: what each capture must produce, pushed when the capture is issued
  task automatic drive(bit r, bit m, bit e, bit rd, logic [1:0] ss, logic [31:0] ww);
    @(negedge clk);
    rst = r; mode = m; en = e; f_ready = rd; s = ss; w = ww;
    for (int i = 0; i < 2; i++) begin
      int n;
      bit cap;
      exp_t x;
      n = (i == 0) ? 4 : 3;
      if (r) begin
        mptr[i] = 0; mdcnt[i] = 0; mprev[i] = 0; mv[i] = 0; rp[i] = wp[i];
        continue;
      end
      cap = e && (!mv[i] || rd);
      if (m && !mprev[i]) begin mptr[i] = 0; mdcnt[i] = 0; end
      if (cap) begin
        x = '0;
        if (m) begin
          x.ch = 2'(mptr[i]);
          x.f = ww[mptr[i]*8 +: 8];
          mdcnt[i]++;
          if (mdcnt[i] == DW) begin
            mdcnt[i] = 0;
            mptr[i] = (mptr[i] + 1) % n;
            x.wrap = (mptr[i] == 0);
          end
        end else begin
          x.ch = ss;
          x.f = (int'(ss) < n) ? ww[int'(ss)*8 +: 8] : 8'h00;
          x.err = (int'(ss) >= n);
        end
        fifo[i][wp[i] % 16] = x;
        wp[i]++;
      end
      mv[i] = cap || (mv[i] && !rd);
      mprev[i] = m;
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("reset", i, {fo[i], cho[i], fvo[i], wro[i], ero[i]}, 0);
        lf[i] = 0; lc[i] = 0;
      end else if (!pv[i] || f_ready) begin
        if (fvo[i]) begin
          chk("sample_present", i, 32'(wp[i] != rp[i]), 1);
          if (wp[i] != rp[i]) begin
            chk("sample", i, {fo[i], cho[i], wro[i], ero[i]}, fifo[i][rp[i] % 16]);
            rp[i]++;
          end
          lf[i] = fo[i]; lc[i] = cho[i];
        end else begin
          chk("idle", i, {wp[i] != rp[i], wro[i], ero[i]}, 0);
          rp[i] = wp[i];
        end
      end else chk("stall", i, {fvo[i], fo[i], cho[i], wro[i], ero[i]}, {1'b1, lf[i], lc[i], 2'b00});
      pv[i] = rst ? 1'b0 : fvo[i];
    end
  end
  initial begin
    logic [31:0] wv;
    wv = 32'h44332211;
    repeat (2) drive(1, 0, 0, 0, 0, wv);
    drive(0, 0, 1, 1, 2, wv);
    repeat (2) drive(0, 0, 0, 1, 2, wv);
    drive(0, 0, 1, 1, 2, wv);
    repeat (3) drive(0, 0, 1, 0, 1, wv);
    drive(0, 0, 1, 1, 1, wv);
    drive(0, 0, 0, 1, 0, wv);
    drive(0, 0, 1, 1, 3, wv);
    repeat (2) drive(0, 0, 0, 1, 3, wv);
    repeat (13) drive(0, 1, 1, 1, 0, wv);
    repeat (2) drive(0, 0, 0, 1, 0, wv);
    repeat (2) drive(0, 1, 1, 1, 0, wv);
    drive(0, 0, 1, 1, 1, wv);
    repeat (2) drive(0, 1, 1, 0, 0, wv);
    repeat (3) drive(0, 1, 1, 1, 0, wv);
    drive(1, 1, 1, 1, 0, wv);
    repeat (2) drive(0, 1, 1, 1, 0, wv);
    for (int t = 0; t < 600; t++) begin
      drive($urandom_range(0, 63) == 0, ($urandom_range(0, 7) == 0) ? ~mode : mode,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom);
    end
    repeat (3) drive(0, 0, 0, 1, 0, wv);
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) chk("drain", i, 32'(wp[i] - rp[i]), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_scan_reg.md
MUX_SCAN_REG -- requirements
Module: mux_scan_reg

Interface
REQ-001 The block SHALL have parameter N, default 4: number of data channels, 2..16.
REQ-002 The block SHALL have parameter W, default 8: data width per channel, 1..32.
REQ-003 The block SHALL have parameter DWELL, default 2: accepted captures per channel in scan mode, 1..255.
REQ-004 The block SHALL derive SW = max(1, clog2(N)) as the selector width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port w, input, N*W bits: packed data inputs; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 The block SHALL have port s, input, SW bits: manual channel select.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 selects manual mode, 1 selects scan mode.
REQ-010 The block SHALL have port en, input, 1 bit: capture request.
REQ-011 The block SHALL have port f_ready, input, 1 bit: downstream accepts f.
REQ-012 The block SHALL have port f, output reg, W bits: registered selected data.
REQ-013 The block SHALL have port ch, output reg, SW bits: channel index f was taken from.
REQ-014 The block SHALL have port f_valid, output reg, 1 bit: f/ch hold an unconsumed sample.
REQ-015 The block SHALL have port wrap, output reg, 1 bit: one-cycle pulse when the scan pointer wraps from N-1 to 0.
REQ-016 The block SHALL have port err, output reg, 1 bit: one-cycle pulse on a manual capture with s >= N.

Function
REQ-017 A capture SHALL occur in a cycle iff en=1 and (f_valid=0 or f_ready=1).
REQ-018 On capture, f, ch and f_valid=1 SHALL appear the next cycle, giving a latency of 1 clock.
REQ-019 If f_valid=1 and f_ready=0, f, ch and f_valid SHALL hold unchanged (stall), and en SHALL be ignored.
REQ-020 If f_valid=1, f_ready=1 and en=0, f_valid SHALL clear next cycle, and f and ch SHALL hold.
REQ-021 A manual capture (mode=0) SHALL load f with channel s and set ch=s.
REQ-022 A manual capture with s >= N SHALL load f=0 and ch=s, set f_valid=1, and pulse err=1 for one cycle.
REQ-023 Scan state SHALL consist of pointer ptr (SW bits) and dwell counter dcnt (8 bits).
REQ-024 A scan capture (mode=1) SHALL load f with channel ptr, set ch=ptr, and increment dcnt.
REQ-025 When a scan capture makes dcnt reach DWELL, dcnt SHALL return to 0 and ptr SHALL advance by 1.
REQ-026 When that advance takes ptr from N-1 to 0, wrap SHALL pulse 1 in the same cycle f updates.
REQ-027 ptr and dcnt SHALL change only on scan captures; stalls and idle cycles SHALL leave them unchanged.
REQ-028 The block SHALL use an FSM with states MANUAL and SCAN, tracking mode with a one-cycle registration.
REQ-029 On the MANUAL->SCAN transition (mode sampled 1 while in MANUAL), ptr and dcnt SHALL be cleared to 0.
REQ-030 On that transition cycle, a capture SHALL use channel 0.
REQ-031 On the SCAN->MANUAL transition, ptr and dcnt SHALL be retained but unused until the next MANUAL->SCAN transition clears them.
REQ-032 A mode change while stalled SHALL NOT alter f or ch; the held sample SHALL drain first.
REQ-033 wrap and err SHALL be 0 in every cycle not named in REQ-022 and REQ-026.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL set f=0, ch=0, f_valid=0, wrap=0, err=0, ptr=0, dcnt=0, and FSM state MANUAL.
REQ-035 rst SHALL have priority over all other inputs.
REQ-036 A capture pending in the same cycle as rst SHALL be discarded.
REQ-037 rst asserted mid-scan or mid-stall SHALL lose the held sample and restart at channel 0.

Verification
REQ-038 The bench SHALL cover the manual scenario (N=4, W=8): w={8'h44,8'h33,8'h22,8'h11}, mode=0, s=2, en=1, f_ready=1 -> next cycle f=8'h33, ch=2, f_valid=1; with en then dropped, f_valid=0 one cycle later.
REQ-039 The bench SHALL cover the stall scenario: f_valid=1, f_ready=0, en=1, s changed to 1 for 3 cycles -> f=8'h33 and ch=2 are held; after f_ready=1, f=8'h22 and ch=1 the following cycle.
REQ-040 The bench SHALL cover the scan scenario (DWELL=2, mode=1, en=1, f_ready=1 for 8 cycles) -> ch sequence 0,0,1,1,2,2,3,3, and wrap=1 only in the cycle the second ch=3 sample appears.
REQ-041 The bench SHALL cover the out-of-range scenario (N=3, SW=2): manual capture with s=3 -> f=0, ch=3, f_valid=1, err=1 for exactly one cycle.
REQ-042 The bench SHALL cover the mode-switch scenario: scan stopped at ptr=2, dcnt=1, then mode=0 for 2 cycles, then mode=1 with en=1 -> first scan sample has ch=0.
REQ-043 The bench SHALL cover the reset scenario: rst=1 for one cycle during a scan with en=1 -> the next cycle shows f=0, ch=0, f_valid=0, wrap=0, err=0; a subsequent scan capture yields ch=0.
